// File: rtl/oit_sync_fifo_pkg.sv
// Shared helpers for the oit_sync_fifo block: width sizing function used by
// the pointer counters and the occupancy register.
package oit_sync_fifo_pkg;

   // Number of bits needed to encode 'value' distinct states (minimum 1).
   function automatic int unsigned oitBits(input int unsigned value);
      int unsigned bits;
      if (value <= 32'd1) begin
         bits = 32'd1;
      end else begin
         bits = $clog2(value);
      end
      return bits;
   endfunction

endpackage

// File: rtl/oit_fifo_ptr.sv
// Modulo-COUNT wrap counter with enable. Advances 0,1,..,COUNT-1,0,...
// so non-power-of-2 depths never alias into unused indices.
module oit_fifo_ptr
   import oit_sync_fifo_pkg::*;
#(
   parameter int unsigned COUNT = 4,
   localparam int unsigned PtrW = oitBits(COUNT)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   output logic [PtrW-1:0] value
);

   localparam logic [PtrW-1:0] Last = PtrW'(COUNT - 1);

   logic [PtrW-1:0] value_q;
   logic [PtrW-1:0] value_d;

   // Next pointer: wrap to zero from the last index, otherwise increment.
   always_comb begin
      value_d = value_q;
      if (enable) begin
         if (value_q == Last) begin
            value_d = '0;
         end else begin
            value_d = value_q + 1'b1;
         end
      end
   end

   // Pointer register, cleared asynchronously.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/oit_sync_fifo.sv
// Synchronous FIFO with valid/ready handshakes on both sides. Storage is a
// register array addressed by two modulo-DEPTH pointers; flags come only from
// the registered occupancy so there is no in_valid/out_ready -> flag path.
module oit_sync_fifo
   import oit_sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned LevelW = oitBits(DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [LevelW-1:0] level
);

   localparam int unsigned PtrW = oitBits(DEPTH);
   localparam logic [LevelW-1:0] Full = LevelW'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [PtrW-1:0]   wr_ptr;
   logic [PtrW-1:0]   rd_ptr;
   logic [LevelW-1:0] level_q;
   logic [LevelW-1:0] level_d;
   logic              push;
   logic              pop;

   assign out_valid = (level_q != '0);
   assign in_ready  = (level_q != Full);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   oit_fifo_ptr #(
      .COUNT (DEPTH)
   ) u_wr_ptr (
      .clock  (clock),
      .reset  (reset),
      .enable (push),
      .value  (wr_ptr)
   );

   oit_fifo_ptr #(
      .COUNT (DEPTH)
   ) u_rd_ptr (
      .clock  (clock),
      .reset  (reset),
      .enable (pop),
      .value  (rd_ptr)
   );

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr] <= in_data;
      end
   end

   // Occupancy next state: simultaneous push and pop cancel out.
   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + 1'b1;
      end else if (pop && !push) begin
         level_d = level_q - 1'b1;
      end
   end

   // Occupancy register; async clear discards contents immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         level_q <= '0;
      end else begin
         level_q <= level_d;
      end
   end

   // Head entry, masked to zero so stale storage never leaks out.
   always_comb begin
      out_data = '0;
      if (out_valid) begin
         out_data = mem_q[rd_ptr];
      end
   end

   assign level = level_q;

endmodule

// File: tb/tb_oit_sync_fifo.sv
// Directed bench for oit_sync_fifo with WIDTH=8, DEPTH=3.
module tb_oit_sync_fifo;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 3;
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic             clock;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [LW-1:0]    level;

   int total;
   int bad;

   oit_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      step();
      step();
      reset = 1'b1;
      step();
      step();
      total++; if (level !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
   endtask

   task automatic test_fill();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      step();
      total++; if (level !== 2'd1) begin bad++; $display("FAIL fill1_level got=%0d want=1", level); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fill1_out_valid got=%b want=1", out_valid); end
      total++; if (out_data !== 8'h11) begin bad++; $display("FAIL fill1_out_data got=%h want=11", out_data); end
      in_data = 8'h22;
      step();
      total++; if (level !== 2'd2) begin bad++; $display("FAIL fill2_level got=%0d want=2", level); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill2_in_ready got=%b want=1", in_ready); end
      in_data = 8'h33;
      step();
      total++; if (level !== 2'd3) begin bad++; $display("FAIL fill3_level got=%0d want=3", level); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill3_in_ready got=%b want=0", in_ready); end
      total++; if (out_data !== 8'h11) begin bad++; $display("FAIL fill3_out_data got=%h want=11", out_data); end
      in_data = 8'h44;
      step();
      total++; if (level !== 2'd3) begin bad++; $display("FAIL overflow_level got=%0d want=3", level); end
      total++; if (out_data !== 8'h11) begin bad++; $display("FAIL overflow_out_data got=%h want=11", out_data); end
      in_valid = 1'b0;
   endtask

   task automatic test_drain();
      logic [WIDTH-1:0] exp_data [3];
      exp_data[0] = 8'h11;
      exp_data[1] = 8'h22;
      exp_data[2] = 8'h33;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (out_data !== exp_data[i]) begin
            bad++;
            $display("FAIL drain_data[%0d] got=%h want=%h", i, out_data, exp_data[i]);
         end
         step();
         if (i == 0) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready got=%b want=1", in_ready); end
         end
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid got=%b want=0", out_valid); end
      total++; if (level !== 2'd0) begin bad++; $display("FAIL drain_level got=%0d want=0", level); end
      total++; if (out_data !== 8'h00) begin bad++; $display("FAIL drain_out_data got=%h want=00", out_data); end
      step();
      total++; if (level !== 2'd0) begin bad++; $display("FAIL underflow_level got=%0d want=0", level); end
      out_ready = 1'b0;
   endtask

   // Continuous stream through DEPTH=3: pointers wrap 2->0 three times.
   task automatic test_wrap();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h01;
      step();
      for (int i = 2; i <= 10; i++) begin
         total++;
         if (out_data !== 8'(i - 1)) begin
            bad++;
            $display("FAIL wrap_data[%0d] got=%h want=%h", i - 1, out_data, 8'(i - 1));
         end
         total++;
         if (level !== 2'd1) begin
            bad++;
            $display("FAIL wrap_level[%0d] got=%0d want=1", i - 1, level);
         end
         in_data = 8'(i);
         step();
      end
      in_valid = 1'b0;
      total++; if (out_data !== 8'h0A) begin bad++; $display("FAIL wrap_last got=%h want=0a", out_data); end
      step();
      total++; if (level !== 2'd0) begin bad++; $display("FAIL wrap_end_level got=%0d want=0", level); end
      out_ready = 1'b0;
   endtask

   task automatic test_simul();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA1;
      step();
      in_data = 8'hA2;
      step();
      total++; if (level !== 2'd2) begin bad++; $display("FAIL simul_pre_level got=%0d want=2", level); end
      total++; if (out_data !== 8'hA1) begin bad++; $display("FAIL simul_pre_head got=%h want=a1", out_data); end
      in_data   = 8'hA3;
      out_ready = 1'b1;
      step();
      total++; if (level !== 2'd2) begin bad++; $display("FAIL simul_level got=%0d want=2", level); end
      total++; if (out_data !== 8'hA2) begin bad++; $display("FAIL simul_head got=%h want=a2", out_data); end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      step();
      total++; if (out_data !== 8'hA2) begin bad++; $display("FAIL stall_hold got=%h want=a2", out_data); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", out_valid); end
   endtask

   task automatic test_reset_mid();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid got=%b want=0", out_valid); end
      total++; if (level !== 2'd0) begin bad++; $display("FAIL async_level got=%0d want=0", level); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL async_in_ready got=%b want=1", in_ready); end
      step();
      reset = 1'b1;
      step();
      in_valid = 1'b1;
      in_data  = 8'h5A;
      step();
      in_valid = 1'b0;
      total++; if (out_data !== 8'h5A) begin bad++; $display("FAIL post_reset_data got=%h want=5a", out_data); end
      total++; if (level !== 2'd1) begin bad++; $display("FAIL post_reset_level got=%0d want=1", level); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL post_reset_pop got=%b want=0", out_valid); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simul();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
